// File: rtl/sram_pkg.sv
// Shared types for the dual-port byte-enable SRAM: collision policy and
// controller state encoding.
package sram_pkg;

  typedef enum logic [1:0] {
    WRITE_FIRST = 2'd0,
    READ_FIRST  = 2'd1,
    CORRUPT     = 2'd2
  } coll_mode_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result delay line: carries rd_valid and rd_data through RD_LATENCY
// register stages; each data stage only loads when its input is valid.
module sram_rd_pipe #(
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [RD_LATENCY-1:0] v_q;
  logic [WIDTH-1:0]      d_q [RD_LATENCY];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      if (in_valid) d_q[0] <= in_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  // Holding data on idle stages keeps out_data stable whenever out_valid=0.
  assign out_valid = v_q[RD_LATENCY-1];
  assign out_data  = d_q[RD_LATENCY-1];

endmodule

// File: rtl/sram_dp_be.sv
// Dual-port (1W/1R) SRAM with byte enables, self-clearing INIT sequence,
// configurable read latency and same-address collision policy.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter int         DEPTH      = 1024,
  parameter int         RD_LATENCY = 1,
  parameter coll_mode_e COLL_MODE  = WRITE_FIRST
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH/8-1:0]       wr_be,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     init_done,
  output logic                     collision,
  output logic                     state
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  if (WIDTH % 8 != 0) begin : g_chk_width
    $error("sram_dp_be: WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
    $error("sram_dp_be: RD_LATENCY must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $error("sram_dp_be: DEPTH must be at least 2");
  end

  sram_state_e      state_q, state_d;
  logic [AW-1:0]    init_addr_q, init_addr_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             ready;
  logic             wr_in_range, rd_in_range;
  logic             coll, do_write, rd_req;
  logic [WIDTH-1:0] rd_word, rd_now;

  assign ready = (state_q == READY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      INIT: begin
        if (init_addr_q == AW'(DEPTH - 1)) begin
          state_d     = READY;
          init_addr_d = '0;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d     = INIT;
        init_addr_d = '0;
      end
    endcase
  end

  assign wr_in_range = (32'(wr_addr) < DEPTH);
  assign rd_in_range = (32'(rd_addr) < DEPTH);
  assign coll        = ready && wr_en && rd_en && (wr_addr == rd_addr);
  assign do_write    = ready && wr_en && wr_in_range && (|wr_be);
  assign rd_req      = ready && rd_en;

  // Storage is never reset; INIT walks every address and writes zero.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[init_addr_q] <= '0;
    end else if (do_write) begin
      if (coll && COLL_MODE == CORRUPT) begin
        mem[wr_addr] <= '0;
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_word = rd_in_range ? mem[rd_addr] : '0;

  always_comb begin
    rd_now = rd_word;
    if (coll && rd_in_range) begin
      case (COLL_MODE)
        WRITE_FIRST: begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) rd_now[8*b +: 8] = wr_data[8*b +: 8];
          end
        end
        READ_FIRST: rd_now = rd_word;
        default:    rd_now = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) collision <= 1'b0;
    else       collision <= coll;
  end

  sram_rd_pipe #(
    .WIDTH      (WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (rd_req),
    .in_data   (rd_now),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

  assign init_done = ready;
  assign state     = state_q;

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be: three instances (write-first/16, read-first
// latency-2 /12, corrupt/16) share one stimulus stream.
module tb_sram_dp_be;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic [31:0] rd_data0, rd_data1, rd_data2;
  logic        rd_valid0, rd_valid1, rd_valid2;
  logic        init_done0, init_done1, init_done2;
  logic        collision0, collision1, collision2;
  logic        state0, state1, state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_dp_be #(.WIDTH(32), .DEPTH(16), .RD_LATENCY(1), .COLL_MODE(WRITE_FIRST)) u0 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .init_done(init_done0), .collision(collision0), .state(state0));

  sram_dp_be #(.WIDTH(32), .DEPTH(12), .RD_LATENCY(2), .COLL_MODE(READ_FIRST)) u1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .init_done(init_done1), .collision(collision1), .state(state1));

  sram_dp_be #(.WIDTH(32), .DEPTH(16), .RD_LATENCY(1), .COLL_MODE(CORRUPT)) u2 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .init_done(init_done2), .collision(collision2), .state(state2));

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0; wr_be = '0;
  endtask

  // Returns at the negedge where a latency-1 result is visible.
  task automatic rd_issue(input logic [3:0] a);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int f0, f1, f2;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_valid0, collision0, init_done0, state0} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl0: got %b expected 0000", {rd_valid0, collision0, init_done0, state0});
    end
    checks++;
    if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0", rd_data0, rd_data1);
    end
    checks++;
    if ({rd_valid1, init_done1, rd_valid2, init_done2} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl12: got %b expected 0000", {rd_valid1, init_done1, rd_valid2, init_done2});
    end
    rstn = 1'b1;
    f0 = 0; f1 = 0; f2 = 0;
    for (int cnt = 1; cnt <= 100; cnt++) begin
      @(negedge clk);
      if (init_done0 && f0 == 0) f0 = cnt;
      if (init_done1 && f1 == 0) f1 = cnt;
      if (init_done2 && f2 == 0) f2 = cnt;
      if (f0 != 0 && f1 != 0 && f2 != 0) break;
    end
    checks++;
    if (f0 != 16) begin errors++; $display("FAIL init_cycles_d16: got %0d expected 16", f0); end
    checks++;
    if (f1 != 12) begin errors++; $display("FAIL init_cycles_d12: got %0d expected 12", f1); end
    checks++;
    if (f2 != 16) begin errors++; $display("FAIL init_cycles_corrupt: got %0d expected 16", f2); end
  endtask

  task automatic test_init_zero();
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 16) begin
        checks++;
        if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h0) begin
          errors++; $display("FAIL init_zero0 addr %0d: got v=%b d=%h expected v=1 d=0", i-1, rd_valid0, rd_data0);
        end
        checks++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin
          errors++; $display("FAIL init_zero2 addr %0d: got v=%b d=%h expected v=1 d=0", i-1, rd_valid2, rd_data2);
        end
      end
      if (i >= 2) begin
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
          errors++; $display("FAIL init_zero1 addr %0d: got v=%b d=%h expected v=1 d=0", i-2, rd_valid1, rd_data1);
        end
      end
      if (i < 16) begin rd_en = 1'b1; rd_addr = 4'(i); end
      else rd_en = 1'b0;
    end
  endtask

  task automatic test_byte_enable();
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    wr(4'd3, 32'hFFFFFFFF, 4'b0000);
    rd_issue(4'd3);
    checks++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 32'hAA22CC44) begin
      errors++; $display("FAIL byte_en0: got v=%b d=%h expected v=1 d=aa22cc44", rd_valid0, rd_data0);
    end
    checks++;
    if (rd_data2 !== 32'hAA22CC44) begin
      errors++; $display("FAIL byte_en2: got %h expected aa22cc44", rd_data2);
    end
    @(negedge clk);
    checks++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hAA22CC44) begin
      errors++; $display("FAIL byte_en1: got v=%b d=%h expected v=1 d=aa22cc44", rd_valid1, rd_data1);
    end
    checks++;
    if (rd_valid0 !== 1'b0 || rd_data0 !== 32'hAA22CC44) begin
      errors++; $display("FAIL idle_hold0: got v=%b d=%h expected v=0 d=aa22cc44", rd_valid0, rd_data0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dexp [3];
    logic        v0_exp, v1_exp;
    dexp[0] = 32'hA0A0A0A0; dexp[1] = 32'hB1B1B1B1; dexp[2] = 32'hC2C2C2C2;
    wr(4'd0, dexp[0], 4'hF);
    wr(4'd1, dexp[1], 4'hF);
    wr(4'd2, dexp[2], 4'hF);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      v1_exp = (c >= 2 && c <= 4);
      v0_exp = (c >= 1 && c <= 3);
      checks++;
      if (rd_valid1 !== v1_exp || (c >= 2 && rd_data1 !== dexp[(c > 4) ? 2 : c-2])) begin
        errors++; $display("FAIL b2b_lat2 cyc %0d: got v=%b d=%h expected v=%b", c, rd_valid1, rd_data1, v1_exp);
      end
      checks++;
      if (rd_valid0 !== v0_exp || (c >= 1 && rd_data0 !== dexp[(c > 3) ? 2 : c-1])) begin
        errors++; $display("FAIL b2b_lat1 cyc %0d: got v=%b d=%h expected v=%b", c, rd_valid0, rd_data0, v0_exp);
      end
      if (c < 3) begin rd_en = 1'b1; rd_addr = 4'(c); end
      else rd_en = 1'b0;
    end
  endtask

  task automatic test_collision();
    int p0, p1, p2;
    wr(4'd5, 32'h5, 4'hF);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h9; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd5;
    p0 = 0; p1 = 0; p2 = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
      p0 += int'(collision0); p1 += int'(collision1); p2 += int'(collision2);
      if (k == 1) begin
        checks++;
        if ({collision0, collision1, collision2} !== 3'b111) begin
          errors++; $display("FAIL coll_pulse_time: got %b expected 111", {collision0, collision1, collision2});
        end
        checks++;
        if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h9) begin
          errors++; $display("FAIL coll_write_first: got v=%b d=%h expected v=1 d=9", rd_valid0, rd_data0);
        end
        checks++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin
          errors++; $display("FAIL coll_corrupt: got v=%b d=%h expected v=1 d=0", rd_valid2, rd_data2);
        end
      end
      if (k == 2) begin
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h5) begin
          errors++; $display("FAIL coll_read_first: got v=%b d=%h expected v=1 d=5", rd_valid1, rd_data1);
        end
      end
    end
    checks++;
    if (p0 != 1 || p1 != 1 || p2 != 1) begin
      errors++; $display("FAIL coll_pulse_count: got %0d/%0d/%0d expected 1/1/1", p0, p1, p2);
    end
    rd_issue(4'd5);
    checks++;
    if (rd_data0 !== 32'h9 || rd_data2 !== 32'h0) begin
      errors++; $display("FAIL coll_after: got %h/%h expected 9/0", rd_data0, rd_data2);
    end
    @(negedge clk);
    checks++;
    if (rd_data1 !== 32'h9) begin
      errors++; $display("FAIL coll_after_rf: got %h expected 9", rd_data1);
    end
  endtask

  task automatic test_out_of_range();
    wr(4'd13, 32'hCAFEF00D, 4'hF);
    rd_issue(4'd13);
    checks++;
    if (rd_data0 !== 32'hCAFEF00D) begin
      errors++; $display("FAIL oor_inrange_d16: got %h expected cafef00d", rd_data0);
    end
    @(negedge clk);
    checks++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
      errors++; $display("FAIL oor_read: got v=%b d=%h expected v=1 d=0", rd_valid1, rd_data1);
    end
    rd_issue(4'd1);
    @(negedge clk);
    checks++;
    if (rd_data1 !== 32'hB1B1B1B1) begin
      errors++; $display("FAIL oor_unchanged: got %h expected b1b1b1b1", rd_data1);
    end
  endtask

  task automatic test_init_ignore();
    int f0;
    wr(4'd4, 32'h12345678, 4'hF);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 4'd4;
    @(negedge clk);
    rd_en = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if ({rd_valid0, rd_valid1, init_done0} !== 3'b000 || rd_data0 !== 32'h0) begin
      errors++; $display("FAIL reset_midread: got v=%b%b done=%b d=%h expected 000 d=0", rd_valid0, rd_valid1, init_done0, rd_data0);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (state0 !== 1'b0 || init_done0 !== 1'b0) begin
      errors++; $display("FAIL reset_midinit: got state=%b done=%b expected 0/0", state0, init_done0);
    end
    @(negedge clk);
    rstn = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd4;
    f0 = 0;
    for (int cnt = 1; cnt <= 100; cnt++) begin
      @(negedge clk);
      if (cnt == 10) begin wr_en = 1'b0; wr_be = '0; rd_en = 1'b0; end
      if (cnt <= 11) begin
        checks++;
        if ({rd_valid0, rd_valid1, rd_valid2, collision0, collision1, collision2} !== 6'b0) begin
          errors++; $display("FAIL init_ignore cyc %0d: got %b expected 000000", cnt,
                             {rd_valid0, rd_valid1, rd_valid2, collision0, collision1, collision2});
        end
      end
      if (init_done0 && init_done1 && init_done2) begin f0 = cnt; break; end
    end
    checks++;
    if (f0 != 16) begin errors++; $display("FAIL reinit_cycles: got %0d expected 16", f0); end
    rd_issue(4'd4);
    checks++;
    if (rd_data0 !== 32'h0 || rd_data2 !== 32'h0) begin
      errors++; $display("FAIL init_no_write: got %h/%h expected 0/0", rd_data0, rd_data2);
    end
    @(negedge clk);
    checks++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
      errors++; $display("FAIL init_no_write1: got v=%b d=%h expected v=1 d=0", rd_valid1, rd_data1);
    end
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_byte_enable();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_init_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
